lab8_soc_sysid_ext: RTL and testbench
=====================================

// Module: lab8_soc_sysid_ext
// PURPOSE
//  Parametrised system-ID/info Avalon-MM slave; successor to the fixed sysid control slave.
//  Returns ID and build TIMESTAMP constants. Adds:
//  - a 64-bit uptime counter with atomic LO/HI snapshot
//  - control/status registers
//  - NUM_SCRATCH read/write scratch words
//  - configurable read latency
//  Sits on the Nios II data master, readable by software for board/build identification and timing.
// PARAMETERS
//  ID            32'h0000_0000  system ID value, register 0
//  TIMESTAMP     32'd1520803331 build time (Unix seconds), register 1
//  NUM_SCRATCH   2              scratch registers, 1..2
//  READ_LATENCY  1              cycles from read accept to readdatavalid, 1 or 2
// PORTS
//  clock          in   1   system clock
//  reset_n        in   1   asynchronous active-low reset
//  address        in   3   word address
//  read           in   1   read strobe, one word per cycle, no waitrequest
//  write          in   1   write strobe
//  writedata      in   32  write data
//  byteenable     in   4   write byte lanes
//  readdata       out  32  read data, valid only with readdatavalid
//  readdatavalid  out  1   read data valid
// BEHAVIOUR
//  Reset: all outputs 0. Counter, snapshot, scratch and STATUS = 0. CTRL.en = 1.
//  Register map, word address:
//   0  ID         RO
//   1  TIMESTAMP  RO
//   2  UPTIME_LO  RO; read also latches cnt[63:32] into SNAP_HI
//   3  SNAP_HI    RO
//   4  CTRL       bit0 en (RW); bit1 clr (write-1 pulse, reads 0)
//   5  STATUS     bit0 wrapped, sticky, W1C
//   6..6+NUM_SCRATCH-1  SCRATCH, RW with byteenable
//   others        read 0, writes ignored
//  byteenable applies to SCRATCH only. CTRL/STATUS use lane 0 only.
//  Counter:
//   - Increments every cycle while en=1.
//   - At all-ones, wraps to 0 and sets STATUS.wrapped.
//   - clr write zeroes it on the next edge. clr beats increment in the same cycle.
//   - Wrap set beats W1C in the same cycle.
//  Snapshot:
//   - UPTIME_LO returns cnt[31:0], and SNAP_HI captures cnt[63:32].
//   - Both come from the same pre-edge counter value, so LO then HI reads are coherent.
//  Read pipeline:
//   - Read accepted in cycle N.
//   - readdata/readdatavalid asserted in cycle N+READ_LATENCY for exactly 1 cycle each.
//   - Back-to-back reads allowed every cycle; fully pipelined, no bubbles.
//   - readdata = 0 whenever readdatavalid = 0.
//  read+write same cycle, same address: read returns the pre-write value, then the write takes effect.
//  reset_n asserted mid-read: in-flight reads are discarded, no readdatavalid after release.
// STRUCTURE
//  Package lab8_sysid_pkg:
//   - address localparams ADDR_ID..ADDR_SCRATCH0
//   - CTRL/STATUS bit indices
//   - CNT_W = 64
//  Sub-module sysid_uptime_counter:
//   - inputs: en, clr, wrap_clr
//   - outputs: cnt[63:0], wrapped
//  Top level: register decode, SNAP_HI, scratch, READ_LATENCY-deep valid/data shift pipeline.
// TESTING
//  1 Reset; read addr 0, 1 (ID=32'hCAFE0001) -> 32'hCAFE0001, 32'd1520803331 after READ_LATENCY, one-cycle valid.
//  2 Force cnt=64'h0000_0001_FFFF_FFFF; read 2, then 3 -> LO=32'hFFFF_FFFF, HI=32'h1 (not 2).
//  3 Write SCRATCH0 32'h12345678 be=4'b1111, then 32'hAABBCCDD be=4'b0101 -> read 32'h12BB56DD.
//  4 Force cnt all-ones -> next cycle 0, STATUS=1. W1C write 1 -> 0. W1C in the wrap cycle -> stays 1.
//  5 Write CTRL 32'h0 -> counter frozen across 10 cycles. Write CTRL 32'h3 -> cnt=0, then counts; CTRL reads 1.
//  6 READ_LATENCY=2, reads on 5 consecutive cycles to addrs 0,1,7,4,6 -> 5 consecutive valids, in order, addr 7 = 0.
//    Assert reset_n mid-stream -> no further valids.

Source files
------------

// File: rtl/lab8_sysid_pkg.sv
// Register map, control/status bit positions and counter width for the sysid slave.
package lab8_sysid_pkg;

  localparam logic [2:0] ADDR_ID        = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] ADDR_UPTIME_LO = 3'd2;
  localparam logic [2:0] ADDR_SNAP_HI   = 3'd3;
  localparam logic [2:0] ADDR_CTRL      = 3'd4;
  localparam logic [2:0] ADDR_STATUS    = 3'd5;
  localparam logic [2:0] ADDR_SCRATCH0  = 3'd6;

  localparam int CTRL_EN_BIT        = 0;
  localparam int CTRL_CLR_BIT       = 1;
  localparam int STATUS_WRAPPED_BIT = 0;

  localparam int CNT_W = 64;

endpackage

// File: rtl/sysid_uptime_counter.sv
// Free-running 64-bit uptime counter with sticky wrap flag.
// Latency: clr/en/wrap_clr act on the next edge; no backpressure.
module sysid_uptime_counter
  import lab8_sysid_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             wrap_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             wrapped
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrapped_q, wrapped_d;

  always_comb begin
    cnt_d     = cnt_q;
    wrapped_d = wrapped_q;
    if (wrap_clr) wrapped_d = 1'b0;
    // clear wins over counting; a wrap set wins over the W1C above
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (&cnt_q) begin
        cnt_d     = '0;
        wrapped_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      wrapped_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign cnt     = cnt_q;
  assign wrapped = wrapped_q;

endmodule

// File: rtl/lab8_soc_sysid_ext.sv
// System-ID/info Avalon-MM slave: ID, build timestamp, uptime with coherent HI snapshot, ctrl/status, scratch.
// Latency: READ_LATENCY cycles, fully pipelined; no waitrequest, never backpressures.
module lab8_soc_sysid_ext
  import lab8_sysid_pkg::*;
#(
  parameter logic [31:0] ID           = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'd1520803331,
  parameter int          NUM_SCRATCH  = 2,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  logic [CNT_W-1:0]        cnt;
  logic                    wrapped;
  logic                    en_q, en_d;
  logic [31:0]             snap_hi_q, snap_hi_d;
  logic [31:0]             scratch_q [NUM_SCRATCH];
  logic [31:0]             scratch_d [NUM_SCRATCH];
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [31:0]             dat_q [READ_LATENCY];
  logic [31:0]             dat_d [READ_LATENCY];
  logic                    ctrl_wr, status_wr, cnt_clr, wrap_clr;
  logic [31:0]             rd_mux;

  always_comb begin
    ctrl_wr   = write && (address == ADDR_CTRL) && byteenable[0];
    status_wr = write && (address == ADDR_STATUS) && byteenable[0];
    cnt_clr   = ctrl_wr && writedata[CTRL_CLR_BIT];
    wrap_clr  = status_wr && writedata[STATUS_WRAPPED_BIT];
    en_d      = ctrl_wr ? writedata[CTRL_EN_BIT] : en_q;
  end

  sysid_uptime_counter u_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .en       (en_q),
    .clr      (cnt_clr),
    .wrap_clr (wrap_clr),
    .cnt      (cnt),
    .wrapped  (wrapped)
  );

  // HI is captured from the same pre-edge count that LO returns
  always_comb begin
    snap_hi_d = snap_hi_q;
    if (read && (address == ADDR_UPTIME_LO)) snap_hi_d = cnt[63:32];
  end

  always_comb begin
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      scratch_d[i] = scratch_q[i];
      if (write && (address == ADDR_SCRATCH0 + 3'(i))) begin
        for (int b = 0; b < 4; b++) begin
          if (byteenable[b]) scratch_d[i][8*b +: 8] = writedata[8*b +: 8];
        end
      end
    end
  end

  // Reads see pre-edge state, so a same-cycle write to the same word is not visible yet
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_ID:        rd_mux = ID;
      ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
      ADDR_UPTIME_LO: rd_mux = cnt[31:0];
      ADDR_SNAP_HI:   rd_mux = snap_hi_q;
      ADDR_CTRL:      rd_mux[CTRL_EN_BIT] = en_q;
      ADDR_STATUS:    rd_mux[STATUS_WRAPPED_BIT] = wrapped;
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (address == ADDR_SCRATCH0 + 3'(i)) rd_mux = scratch_q[i];
        end
      end
    endcase
  end

  always_comb begin
    vld_d[0] = read;
    dat_d[0] = read ? rd_mux : 32'h0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      en_q      <= 1'b1;
      snap_hi_q <= '0;
      vld_q     <= '0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      en_q      <= en_d;
      snap_hi_q <= snap_hi_d;
      vld_q     <= vld_d;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= scratch_d[i];
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= dat_d[i];
    end
  end

  assign readdata      = dat_q[READ_LATENCY-1];
  assign readdatavalid = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_lab8_soc_sysid_ext.sv
// Directed bench: latency-1 instance for register behaviour, latency-2 instance for pipelining and reset flush.
module tb_lab8_soc_sysid_ext;

  localparam logic [31:0] TB_ID = 32'hCAFE0001;
  localparam logic [31:0] TB_TS = 32'd1520803331;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] rdata1, rdata2;
  logic        rvld1, rvld2;
  logic [63:0] force_val;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  lab8_soc_sysid_ext #(.ID(TB_ID), .TIMESTAMP(TB_TS), .NUM_SCRATCH(2), .READ_LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(rdata1), .readdatavalid(rvld1)
  );

  lab8_soc_sysid_ext #(.ID(TB_ID), .TIMESTAMP(TB_TS), .NUM_SCRATCH(1), .READ_LATENCY(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(rdata2), .readdatavalid(rvld2)
  );

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with latency-1 outputs sampled.
  task automatic rd1(input logic [2:0] a, output logic [31:0] d, output logic v);
    address = a;
    read    = 1'b1;
    @(negedge clock);
    read = 1'b0;
    d    = rdata1;
    v    = rvld1;
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        v;
    rd1(a, d, v);
    chk({nm, " valid"}, {31'h0, v}, 32'h1);
    chk(nm, d, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    @(negedge clock);
    write      = 1'b0;
    byteenable = '0;
  endtask

  task force_cnt(input logic [63:0] v);
    force_val = v;
    force dut1.u_cnt.cnt_q = force_val;
    #1;
    release dut1.u_cnt.cnt_q;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset vld1", {31'h0, rvld1}, 32'h0);
    chk("reset data1", rdata1, 32'h0);
    chk("reset vld2", {31'h0, rvld2}, 32'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    vec_t        vecs [7];
    logic [31:0] d;
    logic        v;
    logic [2:0]  s_addr [5];
    logic [31:0] s_exp [5];

    vecs[0] = '{3'd0, TB_ID};
    vecs[1] = '{3'd1, TB_TS};
    vecs[2] = '{3'd3, 32'h0};
    vecs[3] = '{3'd4, 32'h1};
    vecs[4] = '{3'd5, 32'h0};
    vecs[5] = '{3'd6, 32'h0};
    vecs[6] = '{3'd7, 32'h0};

    do_reset();

    // reset-state register table, each read is a single-cycle valid
    foreach (vecs[i]) begin
      rd1(vecs[i].addr, d, v);
      chk($sformatf("tbl vld a%0d", vecs[i].addr), {31'h0, v}, 32'h1);
      chk($sformatf("tbl dat a%0d", vecs[i].addr), d, vecs[i].exp);
      @(negedge clock);
      chk($sformatf("tbl vld drop a%0d", vecs[i].addr), {31'h0, rvld1}, 32'h0);
      chk($sformatf("tbl dat drop a%0d", vecs[i].addr), rdata1, 32'h0);
    end

    // coherent LO/HI snapshot across a carry
    force_cnt(64'h0000_0001_FFFF_FFFF);
    rd_chk("snap lo", 3'd2, 32'hFFFF_FFFF);
    rd_chk("snap hi", 3'd3, 32'h0000_0001);

    // scratch byte lanes
    wr(3'd6, 32'h1234_5678, 4'b1111);
    wr(3'd6, 32'hAABB_CCDD, 4'b0101);
    rd_chk("scratch0 be", 3'd6, 32'h12BB_56DD);

    // read and write of the same word in one cycle
    wr(3'd7, 32'h1111_1111, 4'b1111);
    address    = 3'd7;
    writedata  = 32'h2222_2222;
    byteenable = 4'b1111;
    write      = 1'b1;
    read       = 1'b1;
    @(negedge clock);
    write = 1'b0;
    read  = 1'b0;
    byteenable = '0;
    chk("rw same vld", {31'h0, rvld1}, 32'h1);
    chk("rw same old", rdata1, 32'h1111_1111);
    rd_chk("rw same new", 3'd7, 32'h2222_2222);

    // wrap and sticky status
    force_cnt(64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clock);
    rd_chk("wrap lo", 3'd2, 32'h0);
    rd_chk("wrap hi", 3'd3, 32'h0);
    rd_chk("wrap status", 3'd5, 32'h1);
    wr(3'd5, 32'h1, 4'b0001);
    rd_chk("w1c status", 3'd5, 32'h0);
    force_cnt(64'hFFFF_FFFF_FFFF_FFFF);
    wr(3'd5, 32'h1, 4'b0001);
    rd_chk("wrap beats w1c", 3'd5, 32'h1);
    wr(3'd5, 32'h1, 4'b0001);
    rd_chk("w1c again", 3'd5, 32'h0);

    // freeze, then clear-and-run
    force_cnt(64'h0000_0000_0000_0100);
    wr(3'd4, 32'h0, 4'b0001);
    repeat (10) @(negedge clock);
    rd_chk("frozen lo", 3'd2, 32'h0000_0101);
    rd_chk("frozen hi", 3'd3, 32'h0);
    rd_chk("ctrl off", 3'd4, 32'h0);
    wr(3'd4, 32'h3, 4'b0001);
    rd_chk("clr lo", 3'd2, 32'h0);
    rd_chk("run lo", 3'd2, 32'h1);
    rd_chk("ctrl on", 3'd4, 32'h1);

    // latency-2 instance: five back-to-back reads
    do_reset();
    @(negedge clock);
    wr(3'd6, 32'h5A5A_0F0F, 4'b1111);
    s_addr[0] = 3'd0; s_exp[0] = TB_ID;
    s_addr[1] = 3'd1; s_exp[1] = TB_TS;
    s_addr[2] = 3'd7; s_exp[2] = 32'h0;
    s_addr[3] = 3'd4; s_exp[3] = 32'h1;
    s_addr[4] = 3'd6; s_exp[4] = 32'h5A5A_0F0F;
    for (int c = 0; c < 9; c++) begin
      if (c >= 2 && c <= 6) begin
        chk($sformatf("l2 vld c%0d", c), {31'h0, rvld2}, 32'h1);
        chk($sformatf("l2 dat c%0d", c), rdata2, s_exp[c-2]);
      end else begin
        chk($sformatf("l2 idle vld c%0d", c), {31'h0, rvld2}, 32'h0);
        chk($sformatf("l2 idle dat c%0d", c), rdata2, 32'h0);
      end
      if (c < 5) begin
        address = s_addr[c];
        read    = 1'b1;
      end else begin
        read = 1'b0;
      end
      @(negedge clock);
    end

    // reset with reads still in flight
    address = 3'd0;
    read    = 1'b1;
    @(negedge clock);
    address = 3'd1;
    @(negedge clock);
    reset_n = 1'b0;
    read    = 1'b0;
    #1;
    chk("flush vld2 in reset", {31'h0, rvld2}, 32'h0);
    chk("flush dat2 in reset", rdata2, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      chk($sformatf("flush vld2 c%0d", c), {31'h0, rvld2}, 32'h0);
      chk($sformatf("flush vld1 c%0d", c), {31'h0, rvld1}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
